// File: rtl/byte_serializer.sv
// Byte-to-async-serial frame generator: start bit, DATA_W data bits LSB first, STOP_BITS stop bits.
// A one-entry holding register lets the next byte arrive while the current frame shifts out.
module byte_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              busy
);

    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("byte_serializer: illegal CLKS_PER_BIT or STOP_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_n;
    logic                hold_full;
    logic                drain;
    logic [DATA_W-1:0]   hold;
    logic [DATA_W-1:0]   shifter, shifter_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic                ser_n;
    logic                bit_end;

    assign in_ready = !hold_full;
    assign busy     = (state != IDLE) || hold_full;
    assign bit_end  = (baud_cnt == '0);

    always_comb begin
        state_n   = state;
        shifter_n = shifter;
        bit_n     = bit_cnt;
        baud_n    = baud_cnt;
        ser_n     = ser_out;
        drain     = 1'b0;
        case (state)
            IDLE: begin
                ser_n = 1'b1;
                if (hold_full) begin
                    drain     = 1'b1;
                    shifter_n = hold;
                    state_n   = START;
                    ser_n     = 1'b0;
                    baud_n    = BAUD_LAST;
                end
            end
            START: begin
                baud_n = bit_end ? BAUD_LAST : baud_cnt - 1'b1;
                if (bit_end) begin
                    state_n = DATA;
                    ser_n   = shifter[0];
                    bit_n   = '0;
                end
            end
            DATA: begin
                baud_n = bit_end ? BAUD_LAST : baud_cnt - 1'b1;
                if (bit_end) begin
                    if (bit_cnt == LAST_DATA) begin
                        state_n = STOP;
                        ser_n   = 1'b1;
                        bit_n   = '0;
                    end else begin
                        shifter_n = shifter >> 1;
                        ser_n     = shifter_n[0];
                        bit_n     = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                baud_n = bit_end ? BAUD_LAST : baud_cnt - 1'b1;
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_n = '0;
                        // A waiting byte starts its frame immediately, with no idle cycle.
                        if (hold_full) begin
                            drain     = 1'b1;
                            shifter_n = hold;
                            state_n   = START;
                            ser_n     = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ser_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            shifter   <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            ser_out   <= 1'b1;
        end else begin
            state    <= state_n;
            shifter  <= shifter_n;
            bit_cnt  <= bit_n;
            baud_cnt <= baud_n;
            ser_out  <= ser_n;
            if (drain) begin
                hold_full <= 1'b0;
            end else if (in_valid && !hold_full) begin
                hold_full <= 1'b1;
            end
        end
    end

    // Holding register carries only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            hold <= in_data;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: default instance plus a CLKS_PER_BIT=1, STOP_BITS=2 instance.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       iv0 = 1'b0, iv1 = 1'b0;
    logic [7:0] id0 = 8'h00, id1 = 8'h00;
    logic       rdy0, ser0, busy0;
    logic       rdy1, ser1, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    bit         exp_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    byte_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(rdy0),
        .in_data(id0), .ser_out(ser0), .busy(busy0)
    );

    byte_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
        .in_data(id1), .ser_out(ser1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, stop 1s, every bit repeated cpb times.
    function automatic void add_frame(input logic [7:0] b, input int cpb, input int sb);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        foreach (bits[i]) repeat (cpb) exp_q.push_back(bits[i]);
    endfunction

    // Offers every byte of tx_q back to back (valid held high) and checks each cycle.
    // Edge k counts from 0 at the first edge inside the task.
    task automatic stream(input int d, input int ncyc, input string tag);
        int cpb, sb, fl, n, sent;
        int acc_e[$];
        logic rdy, ser, bsy, exp_ser, exp_rdy, v;
        cpb = (d != 0) ? 1 : 4;
        sb  = (d != 0) ? 2 : 1;
        fl  = (1 + 8 + sb) * cpb;
        n   = tx_q.size();
        sent = 0;
        exp_q.delete();
        foreach (tx_q[i]) add_frame(tx_q[i], cpb, sb);
        for (int k = 0; k < ncyc; k++) begin
            v = (sent < n);
            if (d == 0) begin iv0 = v; id0 = v ? tx_q[sent] : 8'h00; end
            else        begin iv1 = v; id1 = v ? tx_q[sent] : 8'h00; end
            rdy = (d != 0) ? rdy1 : rdy0;
            @(posedge clk);
            if (v && rdy) begin
                acc_e.push_back(k);
                sent++;
            end
            #1;
            ser = (d != 0) ? ser1 : ser0;
            bsy = (d != 0) ? busy1 : busy0;
            rdy = (d != 0) ? rdy1 : rdy0;
            exp_ser = (k >= 1 && (k - 1) < exp_q.size()) ? exp_q[k-1] : 1'b1;
            // Byte i sits in the hold from its accept edge until its frame starts at edge 1+i*fl.
            exp_rdy = 1'b1;
            for (int i = 0; i < n; i++) begin
                int a;
                a = (i == 0) ? 0 : 2 + (i - 1) * fl;
                if (k >= a && k < 1 + i * fl) exp_rdy = 1'b0;
            end
            chk({tag, "_ser"}, 32'(ser), 32'(exp_ser));
            chk({tag, "_busy"}, 32'(bsy), 32'(k <= n * fl));
            chk({tag, "_ready"}, 32'(rdy), 32'(exp_rdy));
        end
        iv0 = 1'b0;
        iv1 = 1'b0;
        chk({tag, "_accepted"}, 32'(sent), 32'(n));
        foreach (acc_e[i])
            chk({tag, "_accept_edge"}, 32'(acc_e[i]), 32'((i == 0) ? 0 : 2 + (i - 1) * fl));
    endtask

    initial begin
        // Reset asserted between edges takes effect without a clock.
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_ser0", 32'(ser0), 32'd1);
        chk("rst_async_rdy0", 32'(rdy0), 32'd1);
        chk("rst_async_busy0", 32'(busy0), 32'd0);
        chk("rst_async_ser1", 32'(ser1), 32'd1);
        chk("rst_async_busy1", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            chk("idle_ser", 32'(ser0), 32'd1);
            chk("idle_rdy", 32'(rdy0), 32'd1);
            chk("idle_busy", 32'(busy0), 32'd0);
        end

        tx_q = {8'hA5};
        stream(0, 50, "a5");

        tx_q = {8'h00, 8'hFF, 8'h3C};
        stream(0, 130, "b2b");

        tx_q = {8'($urandom), 8'($urandom), 8'($urandom)};
        stream(0, 130, "rnd0");

        tx_q = {8'h81};
        stream(1, 16, "cpb1");

        tx_q = {8'($urandom), 8'($urandom), 8'($urandom)};
        stream(1, 40, "rnd1");

        // Reset during data bit 3 of 0x5A, with 0x77 waiting in the hold.
        iv0 = 1'b1;
        id0 = 8'h5A;
        @(posedge clk);
        #1;
        id0 = 8'h77;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        id0 = 8'h00;
        repeat (16) @(posedge clk);
        #1;
        chk("mid_bit3_ser", 32'(ser0), 32'd1);
        chk("mid_busy", 32'(busy0), 32'd1);
        chk("mid_rdy", 32'(rdy0), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_ser", 32'(ser0), 32'd1);
        chk("mid_rst_rdy", 32'(rdy0), 32'd1);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ser", 32'(ser0), 32'd1);
            chk("post_rst_busy", 32'(busy0), 32'd0);
        end
        chk("post_rst_rdy", 32'(rdy0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
